// File: rtl/slot_load_scheduler_pkg.sv
// Shared definitions for the slot load scheduler: phase encodings,
// bank geometry and the pointer wrap helper.
package slot_sched_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'b00,
        ST_READY = 2'b01,
        ST_COUNT = 2'b10
    } sched_state_t;

    localparam int SLOTS        = 3;
    localparam int PTR_W        = 2;
    localparam int DEFAULT_TICK = 50_000_000;

    // Slot pointer advance with wrap after the last slot.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SLOTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/slot_load_scheduler_rr_arbiter2.sv
// Two-requester write arbiter for the slot bank. A requester granted in the
// previous cycle is masked so a held request cannot write twice.
// Optional feature: define SLOT_ARB_FIXED_PRIO_EN to make requester 0 win
// every tie instead of alternating.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic win0,
    output logic win1,
    output logic gnt0,
    output logic gnt1
);

    logic elig0;
    logic elig1;

    assign elig0 = req0 & ~gnt0;
    assign elig1 = req1 & ~gnt1;

`ifdef SLOT_ARB_FIXED_PRIO_EN

    // Pick the winner for this edge; requester 0 takes every tie.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (en) begin
            if (elig0) begin
                win0 = 1'b1;
            end else if (elig1) begin
                win1 = 1'b1;
            end
        end
    end

`else

    logic last_grant;

    // Pick the winner for this edge; a tie goes to whoever was not served last.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (en) begin
            if (elig0 && elig1) begin
                if (last_grant) begin
                    win0 = 1'b1;
                end else begin
                    win1 = 1'b1;
                end
            end else begin
                win0 = elig0;
                win1 = elig1;
            end
        end
    end

    // Remember who was served last; reset favours requester 0 on the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (win0) begin
            last_grant <= 1'b0;
        end else if (win1) begin
            last_grant <= 1'b1;
        end
    end

`endif

    // Register the decision so each grant is visible for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
        end else begin
            gnt0 <= win0;
            gnt1 <= win1;
        end
    end

endmodule

// File: rtl/slot_load_scheduler.sv
// Slot load scheduler: fills a three-slot bank from two requesters, combines
// the slots with AND/OR, then counts the result down one step per TICK cycles.
// Optional feature: SLOT_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
module slot_load_scheduler
    import slot_sched_pkg::*;
#(
    parameter int TICK = DEFAULT_TICK,
    parameter int W    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] data0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [W-1:0] data1,
    output logic         gnt1,
    input  logic         skip,
    input  logic         mode,
    input  logic         start,
    output logic [W-1:0] data_out,
    output logic [1:0]   state,
    output logic         done
);

    localparam int TIMER_W = (TICK > 2) ? $clog2(TICK) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TICK - 1);

    sched_state_t       state_q;
    sched_state_t       state_d;
    logic [W-1:0]       slot_q [SLOTS];
    logic [PTR_W-1:0]   ptr_q;
    logic [W-1:0]       acc_q;
    logic [TIMER_W-1:0] timer_q;
    logic               done_q;

    logic               all_full;
    logic               arb_en;
    logic               win0;
    logic               win1;
    logic [W-1:0]       wr_data;
    logic [W-1:0]       combine;

    assign all_full = (slot_q[0] != '0) && (slot_q[1] != '0) && (slot_q[2] != '0);
    assign arb_en   = (state_q == ST_FILL) && !all_full;
    assign wr_data  = win0 ? data0 : data1;
    assign combine  = mode ? (slot_q[0] & slot_q[1] & slot_q[2])
                           : (slot_q[0] | slot_q[1] | slot_q[2]);

    rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (arb_en),
        .req0 (req0),
        .req1 (req1),
        .win0 (win0),
        .win1 (win1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    // Phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase sequencing: full bank -> READY, start -> COUNT, empty acc -> FILL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (all_full)      state_d = ST_READY;
            ST_READY: if (start)         state_d = ST_COUNT;
            ST_COUNT: if (acc_q == '0)   state_d = ST_FILL;
            default:                     state_d = ST_FILL;
        endcase
    end

    // Bank writes, pointer moves, combine capture and the timed countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            ptr_q   <= '0;
            acc_q   <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    if (win0 || win1) begin
                        slot_q[ptr_q] <= wr_data;
                        ptr_q         <= ptr_next(ptr_q);
                    end else if (skip) begin
                        ptr_q <= ptr_next(ptr_q);
                    end
                end
                ST_READY: begin
                    acc_q   <= combine;
                    timer_q <= '0;
                end
                ST_COUNT: begin
                    if (acc_q == '0) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            slot_q[i] <= '0;
                        end
                        ptr_q   <= '0;
                        timer_q <= '0;
                        done_q  <= 1'b1;
                    end else if (timer_q == TIMER_LAST) begin
                        timer_q <= '0;
                        acc_q   <= acc_q - W'(1);
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out = (state_q == ST_FILL) ? slot_q[ptr_q] : acc_q;
    assign state    = state_q;
    assign done     = done_q;

endmodule

// File: tb/tb_slot_load_scheduler.sv
// Self-checking bench for slot_load_scheduler with TICK=4.
// Table-driven vectors plus hand-written countdown and reset sequences.
module tb_slot_load_scheduler;

    localparam int W    = 4;
    localparam int TICK = 4;

    logic         clk;
    logic         rst;
    logic         req0;
    logic [W-1:0] data0;
    logic         gnt0;
    logic         req1;
    logic [W-1:0] data1;
    logic         gnt1;
    logic         skip;
    logic         mode;
    logic         start;
    logic [W-1:0] data_out;
    logic [1:0]   state;
    logic         done;

    int errors;
    int checks;

    typedef struct {
        string        name;
        logic         r0;
        logic [W-1:0] d0;
        logic         r1;
        logic [W-1:0] d1;
        logic         sk;
        logic         md;
        logic         st;
        logic         eg0;
        logic         eg1;
        logic [1:0]   est;
        logic [W-1:0] edo;
        logic         edn;
    } vec_t;

    vec_t tbl[$];

    slot_load_scheduler #(
        .TICK (TICK),
        .W    (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .data0    (data0),
        .gnt0     (gnt0),
        .req1     (req1),
        .data1    (data1),
        .gnt1     (gnt1),
        .skip     (skip),
        .mode     (mode),
        .start    (start),
        .data_out (data_out),
        .state    (state),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkv(string n, logic r0, logic [W-1:0] d0, logic r1,
                                 logic [W-1:0] d1, logic sk, logic md, logic st,
                                 logic eg0, logic eg1, logic [1:0] est,
                                 logic [W-1:0] edo, logic edn);
        vec_t v;
        v.name = n;  v.r0 = r0;  v.d0 = d0;  v.r1 = r1;  v.d1 = d1;
        v.sk = sk;   v.md = md;  v.st = st;
        v.eg0 = eg0; v.eg1 = eg1; v.est = est; v.edo = edo; v.edn = edn;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        req0  = v.r0;
        data0 = v.d0;
        req1  = v.r1;
        data1 = v.d1;
        skip  = v.sk;
        mode  = v.md;
        start = v.st;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic eg0, input logic eg1,
                               input logic [1:0] est, input logic [W-1:0] edo,
                               input logic edn);
        checks++;
        if ({gnt0, gnt1, state, data_out, done} !== {eg0, eg1, est, edo, edn}) begin
            errors++;
            $display("[TB] FAIL %s: got gnt0=%b gnt1=%b state=%0d data_out=%0d done=%b, expected gnt0=%b gnt1=%b state=%0d data_out=%0d done=%b",
                     name, gnt0, gnt1, state, data_out, done, eg0, eg1, est, edo, edn);
        end
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic runTable();
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i].name, tbl[i].eg0, tbl[i].eg1, tbl[i].est, tbl[i].edo, tbl[i].edn);
        end
        tbl.delete();
    endtask

    task automatic clearInputs();
        req0 = 0; data0 = '0; req1 = 0; data1 = '0;
        skip = 0; mode = 0; start = 0;
    endtask

    task automatic resetDut();
        clearInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int cycles;
    int gnt_in_count;

    initial begin
        errors = 0;
        checks = 0;
        clearInputs();
        rst = 1'b1;
        #2;
        checkOutput("reset_state", 0, 0, 2'd0, 4'd0, 0);
        resetDut();

        // Single requester handshake filling 5/6/7, then combine and start.
        tbl.push_back(mkv("hs_w5",      1, 5, 0, 0, 0, 0, 0,  1, 0, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("hs_hold5",   1, 5, 0, 0, 0, 0, 0,  0, 0, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("hs_w6",      1, 6, 0, 0, 0, 0, 0,  1, 0, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("hs_hold6",   1, 6, 0, 0, 0, 0, 0,  0, 0, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("hs_w7",      1, 7, 0, 0, 0, 0, 0,  1, 0, 2'd0, 4'd5, 0));
        tbl.push_back(mkv("hs_ready",   0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd1, 4'd0, 0));
        tbl.push_back(mkv("hs_or",      0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd1, 4'd7, 0));
        tbl.push_back(mkv("hs_and",     0, 0, 0, 0, 0, 1, 0,  0, 0, 2'd1, 4'd4, 0));
        tbl.push_back(mkv("hs_start",   0, 0, 0, 0, 0, 1, 1,  0, 0, 2'd2, 4'd4, 0));
        tbl.push_back(mkv("hs_t1",      0, 0, 0, 0, 0, 1, 0,  0, 0, 2'd2, 4'd4, 0));
        tbl.push_back(mkv("hs_t2",      0, 0, 0, 0, 0, 1, 0,  0, 0, 2'd2, 4'd4, 0));
        tbl.push_back(mkv("hs_t3",      0, 0, 0, 0, 0, 1, 0,  0, 0, 2'd2, 4'd4, 0));
        tbl.push_back(mkv("hs_step",    0, 0, 0, 0, 0, 1, 0,  0, 0, 2'd2, 4'd3, 0));
        runTable();

        // Asynchronous reset in the middle of COUNT.
        #2 rst = 1'b1;
        #1 checkOutput("rst_mid_count", 0, 0, 2'd0, 4'd0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        checkOutput("after_rst_release", 0, 0, 2'd0, 4'd0, 0);

        // Tie after requester 0 was served last.
        resetDut();
        tbl.push_back(mkv("tie_w1",     1, 1, 0, 0, 0, 0, 0,  1, 0, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("tie_idle",   0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd0, 4'd0, 0));
`ifdef SLOT_ARB_FIXED_PRIO_EN
        tbl.push_back(mkv("tie_both",   1, 2, 1, 8, 0, 0, 0,  1, 0, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("tie_next",   1, 2, 1, 8, 0, 0, 0,  0, 1, 2'd0, 4'd1, 0));
`else
        tbl.push_back(mkv("tie_both",   1, 2, 1, 8, 0, 0, 0,  0, 1, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("tie_next",   1, 2, 1, 8, 0, 0, 0,  1, 0, 2'd0, 4'd1, 0));
`endif
        tbl.push_back(mkv("tie_ready",  0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd1, 4'd0, 0));
        tbl.push_back(mkv("tie_or",     0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd1, 4'd11, 0));
        runTable();

        // Both requesters held continuously with data 3 and 9.
        resetDut();
        tbl.push_back(mkv("alt_g0",     1, 3, 1, 9, 0, 0, 0,  1, 0, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("alt_g1",     1, 3, 1, 9, 0, 0, 0,  0, 1, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("alt_g0b",    1, 3, 1, 9, 0, 0, 0,  1, 0, 2'd0, 4'd3, 0));
        tbl.push_back(mkv("alt_full",   1, 3, 1, 9, 0, 0, 0,  0, 0, 2'd1, 4'd0, 0));
        tbl.push_back(mkv("alt_or",     1, 3, 1, 9, 0, 0, 0,  0, 0, 2'd1, 4'd11, 0));
        tbl.push_back(mkv("alt_and",    1, 3, 1, 9, 0, 1, 0,  0, 0, 2'd1, 4'd1, 0));
        tbl.push_back(mkv("alt_start",  0, 0, 0, 0, 0, 1, 1,  0, 0, 2'd2, 4'd1, 0));
        tbl.push_back(mkv("alt_c1",     0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd2, 4'd1, 0));
        tbl.push_back(mkv("alt_c2",     0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd2, 4'd1, 0));
        tbl.push_back(mkv("alt_c3",     0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd2, 4'd1, 0));
        tbl.push_back(mkv("alt_c4",     0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd2, 4'd0, 0));
        tbl.push_back(mkv("alt_done",   0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd0, 4'd0, 1));
        tbl.push_back(mkv("alt_after",  0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd0, 4'd0, 0));
        runTable();

        // Skip with and without a grant, then an AND combine of zero.
        resetDut();
        tbl.push_back(mkv("sk_gnt",     1, 5, 0, 0, 1, 0, 0,  1, 0, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("sk_hold",    1, 5, 0, 0, 0, 0, 0,  0, 0, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("sk_w9",      0, 0, 1, 9, 0, 0, 0,  0, 1, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("sk_alone0",  0, 0, 1, 9, 1, 0, 0,  0, 0, 2'd0, 4'd5, 0));
        tbl.push_back(mkv("sk_alone1",  0, 0, 0, 0, 1, 0, 0,  0, 0, 2'd0, 4'd9, 0));
        tbl.push_back(mkv("sk_alone2",  0, 0, 0, 0, 1, 0, 0,  0, 0, 2'd0, 4'd0, 0));
        tbl.push_back(mkv("sk_w2",      1, 2, 0, 0, 0, 0, 0,  1, 0, 2'd0, 4'd5, 0));
        tbl.push_back(mkv("sk_ready",   1, 2, 0, 0, 0, 0, 0,  0, 0, 2'd1, 4'd0, 0));
        tbl.push_back(mkv("sk_or",      0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd1, 4'd15, 0));
        tbl.push_back(mkv("sk_start0",  0, 0, 0, 0, 0, 1, 1,  0, 0, 2'd2, 4'd0, 0));
        tbl.push_back(mkv("sk_done",    0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd0, 4'd0, 1));
        tbl.push_back(mkv("sk_after",   0, 0, 0, 0, 0, 0, 0,  0, 0, 2'd0, 4'd0, 0));
        runTable();

        // Countdown of 6|3|2 = 7 with a request pending during COUNT.
        resetDut();
        for (int i = 0; i < 3; i++) begin
            req0  = 1'b1;
            data0 = (i == 0) ? 4'd6 : (i == 1) ? 4'd3 : 4'd2;
            tick();
            checkVal($sformatf("cd_gnt%0d", i), int'(gnt0), 1);
            tick();
            req0 = 1'b0;
        end
        checkVal("cd_ready", int'(state), 1);
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        req1  = 1'b1;
        data1 = 4'd4;
        checkOutput("cd_start", 0, 0, 2'd2, 4'd7, 0);
        cycles       = 0;
        gnt_in_count = 0;
        while (cycles < 200 && state != 2'd0) begin
            tick();
            cycles++;
            if (state == 2'd2 && gnt1) gnt_in_count++;
            if (cycles == 4)  checkVal("cd_first_step", int'(data_out), 6);
            if (cycles == 28) checkVal("cd_last_step", int'(data_out), 0);
        end
        checkVal("cd_cycles", cycles, 7 * TICK + 1);
        checkVal("cd_no_gnt_in_count", gnt_in_count, 0);
        checkOutput("cd_done", 0, 0, 2'd0, 4'd0, 1);
        tick();
        checkOutput("cd_pending_served", 0, 1, 2'd0, 4'd0, 0);
        req1 = 1'b0;

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slot_load_scheduler.md
# slot_load_scheduler

Controller for the three-slot 4-bit value bank and its AND/OR countdown datapath. Shares slot write access between two requesters with a registered request/grant handshake. Sequences the bank through fill, ready (combine) and timed countdown phases. Sits between the debounced/edge-detected panel inputs plus a second load source and the display output.

## Interface
- `TICK`, 50_000_000, clock cycles per countdown step (≥2)
- `W`, 4, slot / data width
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0`  in  1  write request, requester 0 (panel path)
- `data0`  in  W  write data, requester 0
- `gnt0`  out  1  registered one-cycle grant, requester 0
- `req1`  in  1  write request, requester 1 (auxiliary source)
- `data1`  in  W  write data, requester 1
- `gnt1`  out  1  registered one-cycle grant, requester 1
- `skip`  in  1  single-cycle pulse: advance slot pointer without writing
- `mode`  in  1  combine select in READY: 1 = AND of slots, 0 = OR
- `start`  in  1  single-cycle pulse: READY → COUNT
- `data_out`  out  W  FILL: slot[ptr]; READY/COUNT: acc
- `state`  out  2  current phase: FILL=00, READY=01, COUNT=10
- `done`  out  1  one-cycle pulse on COUNT → FILL

## Operation
- Reset: slots=0, ptr=0, acc=0, timer=0, state=FILL, gnt0=gnt1=0, done=0, data_out=0, last-grant=1 (requester 0 wins the first tie).
- FILL:
  - Each cycle, one eligible requester is chosen. A requester is eligible when its req=1 and it was not granted in the previous cycle.
  - One eligible: it wins. Both eligible: winner ≠ last-grant (round robin).
  - On the winning edge: slot[ptr] ← its data, ptr ← (ptr+1) mod 3, its gnt=1 for exactly that cycle, last-grant updated.
  - skip with no grant: ptr ← (ptr+1) mod 3. skip in the same cycle as a grant is ignored; ptr advances once.
  - Writing 0 is legal. The slot stays "empty".
  - When registered slots are all nonzero: state ← READY next edge. Requests are then not granted.
- READY: acc ← mode ? (s0&s1&s2) : (s0|s1|s2) every cycle. start=1 → COUNT, timer ← 0, acc holds the current combine value.
- COUNT:
  - timer increments. At timer==TICK-1: timer ← 0, acc ← acc-1.
  - acc==0 (including on entry): slots ← 0, ptr ← 0, timer ← 0, state ← FILL, done=1 for one cycle.
  - skip, start and requests are ignored.
- No gnt is asserted outside FILL. A pending req stays pending and is served in the next FILL.

## Timing
- Grant latency: req high before edge N → gnt high in cycle N..N+1, slot written at edge N. Requester holds req/data until it sees gnt and drops req the following cycle. The non-consecutive rule prevents a double write.
- Bank visible on data_out one cycle after the write.
- FILL → READY: one cycle after the third nonzero slot is written.
- A COUNT step lasts exactly TICK cycles. With acc=k on entry, return to FILL after k·TICK+1 cycles.
- Reset mid-operation: all state returns to reset values immediately. A grant in flight is lost and the requester retries.

## Configuration
- `SLOT_ARB_FIXED_PRIO_EN` defined: requester 0 always wins ties. Last-grant is unused, but the non-consecutive rule is still applied.
- Undefined (default): round robin as above.

## Structure
- Package `slot_sched_pkg`: state encodings (FILL, READY, COUNT), `SLOTS=3`, pointer width 2, default `TICK`.
- Sub-module `rr_arbiter2`: eligibility masking, round-robin/fixed-priority select, last-grant register, registered gnt outputs. The top level holds the FSM, slots, ptr, acc and timer.

## Test plan
- Reset, then req0 with data 5, 6, 7 held per handshake → gnt0 three times, slots 5/6/7, state FILL→READY one cycle after the third write.
- req0 and req1 held continuously (data 3 and 9) → grants alternate 0,1,0 and slots = 3,9,3. With `SLOT_ARB_FIXED_PRIO_EN`: grants 0,1,0 (non-consecutive) and requester 0 wins every tie.
- skip and gnt in the same cycle → ptr advances by 1 only. skip alone → ptr advances and the slot is unchanged.
- Slots 6/3/2, mode=0, start, TICK=4 → acc 7 counts to 0 in 28 cycles, then done pulse, slots cleared, state FILL.
- Slots 4/2/1, mode=1, start → acc=0, return to FILL the next cycle with a done pulse.
- rst asserted mid-COUNT → all outputs 0, state FILL within the same cycle.
